// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: program RAM with registered reads,
// plus memory-mapped UART TX/RX FIFOs, a free-running cycle counter and the halt flag.
module mem_io_responder #(
   parameter int RAM_ADDR_BIT   = 17,
   parameter int FIFO_DEPTH_BIT = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        program_finished,
   output logic        tx_overflow
);
   localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
   localparam int CW    = FIFO_DEPTH_BIT + 1;
   typedef logic [FIFO_DEPTH_BIT-1:0] ptr_t;
   typedef logic [CW-1:0]             cnt_t;

   logic [7:0] ram    [2**RAM_ADDR_BIT];
   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];

   logic [7:0]  mem_din_q;
   ptr_t        tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   ptr_t        rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   cnt_t        tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [31:0] cyc_q, cyc_d, snap_q, snap_d;
   logic        halt_q, halt_d, ovf_q, ovf_d, fin_q, fin_d;

   logic [17:0] addr;
   logic        io, io_rd, io_wr;
   logic        tx_req, tx_push, tx_pop, rx_push, rx_pop, snap_rd, wr_halt;
   logic [7:0]  tx_wdata, io_rdata;
   logic        unused_addr_bits;

   assign addr             = mem_a[17:0];
   assign unused_addr_bits = ^mem_a[31:18];
   assign io               = (addr[17:16] == 2'b11);
   assign io_rd            = rdy_in && io && !mem_wr;
   assign io_wr            = rdy_in && io && mem_wr;

   always_comb begin
      wr_halt  = io_wr && (addr == 18'h30004);
      tx_req   = wr_halt || (io_wr && (addr == 18'h30000) && (mem_dout != 8'h00));
      tx_wdata = wr_halt ? 8'h00 : mem_dout;
      tx_pop   = (tx_cnt_q != '0) && tx_ready;
      // a full FIFO still accepts a write when its head leaves in the same cycle
      tx_push  = tx_req && ((tx_cnt_q != cnt_t'(DEPTH)) || tx_pop);
      rx_push  = rx_valid && (rx_cnt_q != cnt_t'(DEPTH));
      rx_pop   = io_rd && (addr == 18'h30000) && (rx_cnt_q != '0);
      snap_rd  = io_rd && (addr == 18'h30004);

      case (addr)
         18'h30000: io_rdata = (rx_cnt_q != '0) ? rx_mem[rx_rp_q] : 8'h00;
         18'h30004: io_rdata = cyc_q[7:0];
         18'h30005: io_rdata = snap_q[15:8];
         18'h30006: io_rdata = snap_q[23:16];
         18'h30007: io_rdata = snap_q[31:24];
         default:   io_rdata = 8'h00;
      endcase

      tx_wp_d  = tx_wp_q + ptr_t'(tx_push);
      tx_rp_d  = tx_rp_q + ptr_t'(tx_pop);
      tx_cnt_d = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
      rx_wp_d  = rx_wp_q + ptr_t'(rx_push);
      rx_rp_d  = rx_rp_q + ptr_t'(rx_pop);
      rx_cnt_d = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);

      cyc_d  = rdy_in ? cyc_q + 32'd1 : cyc_q;
      snap_d = snap_rd ? cyc_q : snap_q;
      halt_d = halt_q || wr_halt;
      ovf_d  = ovf_q || (tx_req && !tx_push);
      fin_d  = fin_q || (halt_q && (tx_cnt_q == '0));
   end

   // storage arrays carry no reset so they map onto block RAM
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && !io && mem_wr) ram[mem_a[RAM_ADDR_BIT-1:0]] <= mem_dout;
      if (!rst_in && tx_push) tx_mem[tx_wp_q] <= tx_wdata;
      if (!rst_in && rx_push) rx_mem[rx_wp_q] <= rx_data;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mem_din_q <= 8'h00;
      end else if (rdy_in && !mem_wr) begin
         mem_din_q <= io ? io_rdata : ram[mem_a[RAM_ADDR_BIT-1:0]];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
         cyc_q    <= '0;
         snap_q   <= '0;
         halt_q   <= 1'b0;
         ovf_q    <= 1'b0;
         fin_q    <= 1'b0;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_cnt_q <= rx_cnt_d;
         cyc_q    <= cyc_d;
         snap_q   <= snap_d;
         halt_q   <= halt_d;
         ovf_q    <= ovf_d;
         fin_q    <= fin_d;
      end
   end

   assign mem_din          = mem_din_q;
   assign tx_data          = tx_mem[tx_rp_q];
   assign tx_valid         = (tx_cnt_q != '0);
   assign io_buffer_full   = (tx_cnt_q >= cnt_t'(DEPTH - 1));
   assign rx_ready         = (rx_cnt_q != cnt_t'(DEPTH));
   assign program_finished = fin_q;
   assign tx_overflow      = ovf_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: a queue-based reference model predicts read data,
// UART TX bytes and status flags; a negedge monitor compares them as the DUT presents them.
module tb_mem_io_responder;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b0;
   logic [31:0] mem_a = '0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_dout = '0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        program_finished;
   logic        tx_overflow;

   mem_io_responder dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a), .mem_wr(mem_wr),
      .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .program_finished(program_finished),
      .tx_overflow(tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   typedef struct { int due; logic [7:0] d; } rd_e_t;
   typedef struct { int due; bit txv; bit ibf; bit rxr; bit ovf; bit fin; } st_e_t;

   rd_e_t      rd_q[$];
   st_e_t      st_q[$];
   logic [7:0] exp_tx_q[$];

   // reference model state
   logic [7:0]  m_ram[int];
   logic [7:0]  m_tx[$];
   logic [7:0]  m_rx[$];
   logic [31:0] m_cnt = '0, m_snap = '0;
   bit          m_halt = 0, m_ovf = 0, m_fin = 0;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk_in);
      cyc = cyc + 1;
   end

   // monitor
   initial forever begin
      @(negedge clk_in);
      if (st_q.size() > 0 && st_q[0].due == cyc) begin
         st_e_t s;
         s = st_q.pop_front();
         chk("tx_valid", {31'd0, tx_valid}, {31'd0, s.txv});
         chk("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, s.ibf});
         chk("rx_ready", {31'd0, rx_ready}, {31'd0, s.rxr});
         chk("tx_overflow", {31'd0, tx_overflow}, {31'd0, s.ovf});
         chk("program_finished", {31'd0, program_finished}, {31'd0, s.fin});
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
         rd_e_t r;
         r = rd_q.pop_front();
         chk("mem_din", {24'd0, mem_din}, {24'd0, r.d});
      end
      if (!rst_in && tx_valid && tx_ready) begin
         if (exp_tx_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_extra @cycle %0d: got byte %h expected none", cyc, tx_data);
         end else begin
            chk("tx_data", {24'd0, tx_data}, {24'd0, exp_tx_q.pop_front()});
         end
      end
   end

   task automatic tx_write(input logic [7:0] b);
      if (m_tx.size() < 8) begin
         m_tx.push_back(b);
         exp_tx_q.push_back(b);
      end else begin
         m_ovf = 1;
      end
   endtask

   // drive one cycle (called just after a posedge) and advance the model across the next edge
   task automatic step(input bit rst, input bit rdy, input logic [31:0] a, input bit wr,
                       input logic [7:0] d, input bit txr, input bit rxv, input logic [7:0] rxd);
      int          due;
      logic [17:0] o;
      bit          io, fin_n, rxp;
      logic [7:0]  rd;
      st_e_t       s;
      rst_in = rst; rdy_in = rdy; mem_a = a; mem_wr = wr; mem_dout = d;
      tx_ready = txr; rx_valid = rxv; rx_data = rxd;
      due = cyc + 1;
      o   = a[17:0];
      io  = (o[17:16] == 2'b11);
      if (rst) begin
         m_tx.delete(); m_rx.delete(); exp_tx_q.delete();
         m_cnt = '0; m_snap = '0; m_halt = 0; m_ovf = 0; m_fin = 0;
         rd_q.push_back('{due: due, d: 8'h00});
      end else begin
         fin_n = m_fin || (m_halt && m_tx.size() == 0);
         rxp   = rxv && (m_rx.size() < 8);
         if (txr && m_tx.size() > 0) void'(m_tx.pop_front());
         if (rdy) begin
            if (!io && wr) begin
               m_ram[int'(o[16:0])] = d;
            end else if (!io) begin
               if (m_ram.exists(int'(o[16:0]))) rd_q.push_back('{due: due, d: m_ram[int'(o[16:0])]});
            end else if (wr) begin
               if (o == 18'h30000 && d != 8'h00) tx_write(d);
               else if (o == 18'h30004) begin
                  m_halt = 1;
                  tx_write(8'h00);
               end
            end else begin
               rd = 8'h00;
               case (o)
                  18'h30000: if (m_rx.size() > 0) rd = m_rx.pop_front();
                  18'h30004: begin rd = m_cnt[7:0]; m_snap = m_cnt; end
                  18'h30005: rd = m_snap[15:8];
                  18'h30006: rd = m_snap[23:16];
                  18'h30007: rd = m_snap[31:24];
                  default:   rd = 8'h00;
               endcase
               rd_q.push_back('{due: due, d: rd});
            end
            m_cnt = m_cnt + 32'd1;
         end
         if (rxp) m_rx.push_back(rxd);
         m_fin = fin_n;
      end
      s.due = due; s.txv = (m_tx.size() > 0); s.ibf = (m_tx.size() >= 7);
      s.rxr = (m_rx.size() < 8); s.ovf = m_ovf; s.fin = m_fin;
      st_q.push_back(s);
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n, input bit txr);
      for (int i = 0; i < n; i++) step(0, 1, 32'h0003_FFF0, 1, 8'h00, txr, 0, 8'h00);
   endtask
   task automatic wr_b(input logic [31:0] a, input logic [7:0] d, input bit txr);
      step(0, 1, a, 1, d, txr, 0, 8'h00);
   endtask
   task automatic rd_b(input logic [31:0] a, input bit txr);
      step(0, 1, a, 0, 8'h00, txr, 0, 8'h00);
   endtask

   initial begin
      @(posedge clk_in);
      #1;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);

      // RAM write then immediate read-back
      wr_b(32'h0000_0010, 8'hA5, 0);
      rd_b(32'h0000_0010, 0);
      wr_b(32'h0000_0011, 8'h3C, 0);
      rd_b(32'h0000_0011, 0);
      rd_b(32'h0000_0010, 0);

      // TX: zero byte ignored, then drain
      wr_b(32'h0003_0000, 8'h48, 0);
      wr_b(32'h0003_0000, 8'h00, 0);
      wr_b(32'h0003_0000, 8'h69, 0);
      idle(2, 0);
      idle(4, 1);

      // TX fill: io_buffer_full after 7, 8th accepted, 9th dropped
      for (int i = 0; i < 9; i++) wr_b(32'h0003_0000, 8'h41 + 8'(i), 0);
      idle(3, 0);
      idle(12, 1);

      // counter snapshot with a frozen stretch
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(16'h102, 0);
      for (int i = 4; i < 8; i++) rd_b(32'h0003_0000 + 32'(i), 0);
      idle(5, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 32'h0003_0004, 0, 0, 0, 0, 0);
      idle(7, 0);
      for (int i = 4; i < 8; i++) rd_b(32'h0003_0000 + 32'(i), 0);

      // RX path
      step(0, 1, 32'h0003_FFF0, 1, 0, 0, 1, 8'h31);
      step(0, 1, 32'h0003_FFF0, 1, 0, 0, 1, 8'h32);
      for (int i = 0; i < 3; i++) rd_b(32'h0003_0000, 0);
      for (int i = 0; i < 9; i++) step(0, 1, 32'h0003_FFF0, 1, 0, 0, 1, 8'h50 + 8'(i));
      for (int i = 0; i < 9; i++) rd_b(32'h0003_0000, 0);

      // halt and drain, then reset mid-drain
      wr_b(32'h0003_0000, 8'h78, 0);
      wr_b(32'h0003_0004, 8'h00, 0);
      idle(3, 0);
      idle(6, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) wr_b(32'h0003_0000, 8'h61 + 8'(i), 0);
      wr_b(32'h0003_0004, 8'h00, 0);
      idle(1, 1);
      step(1, 0, 0, 0, 0, 1, 0, 0);
      idle(3, 1);

      // randomized traffic
      for (int i = 0; i < 16; i++) wr_b(32'h0000_0100 + 32'(i), 8'($urandom), 0);
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         logic [7:0]  d;
         int          op;
         bit          rdy, txr, rxv, wr;
         op  = $urandom_range(0, 9);
         rdy = ($urandom_range(0, 9) != 0);
         txr = ($urandom_range(0, 1) != 0);
         rxv = ($urandom_range(0, 1) != 0);
         d   = 8'($urandom);
         a   = {14'($urandom), 18'h3FFF0};
         wr  = 1;
         case (op)
            1: a = {14'($urandom), 18'h00100 + 18'($urandom_range(0, 15))};
            2: begin a = {14'($urandom), 18'h00100 + 18'($urandom_range(0, 15))}; wr = 0; end
            3, 4: begin a = {14'($urandom), 18'h30000}; if ($urandom_range(0, 7) == 0) d = 8'h00; end
            5: begin a = {14'($urandom), 18'h30000}; wr = 0; end
            6: begin a = {14'($urandom), 18'h30004 + 18'($urandom_range(0, 3))}; wr = 0; end
            7: begin a = {14'($urandom), 18'h30008 + 18'($urandom_range(0, 7))}; wr = ($urandom_range(0, 1) != 0); end
            8: if ($urandom_range(0, 15) == 0) a = {14'($urandom), 18'h30004};
            default: ;
         endcase
         step(($urandom_range(0, 299) == 0), rdy, a, wr, d, txr, rxv, 8'($urandom));
      end
      idle(20, 1);
      chk("tx_drained", 32'(exp_tx_q.size()), 32'd0);
      chk("reads_checked", 32'(rd_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU byte bus (mem_a / mem_dout / mem_wr / mem_din / io_buffer_full).
- Contains the program RAM with 1-cycle registered reads and the memory-mapped I/O at mem_a[17:16]==2'b11.
- I/O includes a UART TX FIFO, a UART RX FIFO, a free-running cycle counter and the halt flag.
- It is the counterpart that drives the CPU's mem_din and io_buffer_full inputs, in the simulation/FPGA top.

Parameters:
- RAM_ADDR_BIT, 17, RAM byte-address width; RAM size is 2^RAM_ADDR_BIT bytes (128KB).
- FIFO_DEPTH_BIT, 3, log2 of TX and RX FIFO depth (8 entries each).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  CPU-side enable; bus ignored and counter frozen when low
- mem_a  input  32  CPU byte address (bits [17:0] decoded)
- mem_wr  input  1  1 = write, 0 = read
- mem_dout  input  8  CPU write data
- mem_din  output  8  read data, valid the cycle after the read is issued
- io_buffer_full  output  1  TX FIFO almost full
- tx_data  output  8  TX FIFO head byte
- tx_valid  output  1  TX FIFO non-empty
- tx_ready  input  1  UART consumes head when tx_valid && tx_ready
- rx_data  input  8  UART received byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  RX FIFO not full
- program_finished  output  1  halt written and TX FIFO drained
- tx_overflow  output  1  sticky; a TX write was dropped

Behaviour:
Reset (rst_in high at a posedge; has priority over all other events):
- mem_din=0, both FIFOs flushed (tx_valid=0, rx_ready=1), counter=0, snapshot=0, halt flag=0, tx_overflow=0, program_finished=0.
- RAM contents are not cleared.

Decode (only when rdy_in=1; io = mem_a[17:16]==2'b11):
- RAM write (!io, mem_wr): ram[mem_a[RAM_ADDR_BIT-1:0]] <= mem_dout at the posedge.
- RAM read (!io, !mem_wr): mem_din <= ram[index] at the posedge, so data is visible one cycle after the request.
- A write followed by a read of the same address on the next cycle returns the new byte.

I/O reads (registered, same 1-cycle latency):
- 0x30000: returns the RX head and pops it; returns 0x00 with no pop if RX is empty.
- 0x30004: returns counter[7:0] and latches snapshot <= counter.
- 0x30005, 0x30006, 0x30007: return snapshot bytes [15:8], [23:16], [31:24].
- Any other I/O address returns 0x00.

I/O writes:
- 0x30000: mem_dout is pushed to TX. 0x00 is ignored. If TX is full, the byte is dropped and tx_overflow is set.
- 0x30004: sets the halt flag and pushes 0x00 to TX (subject to the same full rule).
- Any other I/O address is ignored.

rdy_in=0:
- No RAM or I/O access, mem_din holds its value, counter holds.
- The TX drain and RX fill sides keep running.

Counter:
- 32-bit, increments by 1 each cycle with rdy_in=1, wraps 0xFFFFFFFF -> 0.

FIFOs:
- Circular, with FIFO_DEPTH_BIT-bit pointers that wrap, and a count of width FIFO_DEPTH_BIT+1.
- A push and a pop in the same cycle leave the count unchanged; this is legal when full (TX pop + push) and when empty with a simultaneous push (data written; pop only if count>0 before the cycle).
- io_buffer_full = TX count >= 2^FIFO_DEPTH_BIT - 1. This one-slot margin covers the CPU write issued in the cycle it samples the flag.
- RX push when rx_valid && rx_ready.

program_finished:
- Equals halt flag && TX empty && TX count==0, registered; it stays high until reset.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 on the next cycle -> mem_din=0xA5 one cycle after the read; an untouched address returns its preloaded value.
- With tx_ready=0, write 'H'(0x48), 0x00, 'i'(0x69) to 0x30000 -> 2 entries, tx_data=0x48; raise tx_ready -> 0x48 then 0x69 delivered on consecutive cycles, tx_valid then falls.
- With tx_ready=0, write 7 bytes -> io_buffer_full=1 after the 7th; the 8th is accepted; a 9th is dropped and tx_overflow=1 and sticks.
- Reset, hold rdy_in=1 for 0x102 cycles, read 0x30004..0x30007 -> bytes form the snapshot taken at the 0x30004 read; with rdy_in low for 10 cycles mid-run, the counter shows no advance over those cycles.
- Push rx bytes 0x31, 0x32, then read 0x30000 three times -> mem_din 0x31, 0x32, 0x00; push 8 bytes -> rx_ready=0.
- Write 'x' then write 0x30004 with tx_ready=0 -> program_finished=0; enable tx_ready -> 'x' then 0x00 drained, program_finished=1 the cycle after empty; assert rst_in mid-drain -> all outputs return to reset values next cycle.
